// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage and its neighbours.
//   WIDTH      operand/result width of the ALU datapath
//   OPW        ALUOp field width
//   alu_op_e   ALUOp encodings understood by the ALU
//   operand_t  one {a, b, op} operand set as carried from decode
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int OPW   = 3;

    typedef enum logic [OPW-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SRL = 3'd4,
        ALU_SRA = 3'd5
    } alu_op_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OPW-1:0]   op;
    } operand_t;

    localparam int OPERAND_W = $bits(operand_t);

endpackage

// File: rtl/alu_issue_buf_sync_fifo.sv
// sync_fifo: single-clock FIFO with the oldest entry always visible on o_head.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-low reset of pointers and count
//   i_push   write i_data at the tail (caller guarantees not full)
//   i_pop    drop the head entry (caller guarantees not empty)
//   i_data   entry to write
//   o_head   entry at the read pointer; meaningless when o_count is 0
//   o_count  number of valid entries, 0..DEPTH
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale data is never used.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/alu_issue_buf.sv
// alu_issue_buf: issue stage in front of a combinational ALU.
// Operand sets from decode queue in a small FIFO; the head entry drives the
// ALU and its result is captured in an output register with a valid/ready
// handshake toward writeback.
// Ports:
//   clk, reset                 clock; synchronous active-low reset
//   in_valid/in_ready          decode handshake; in_a, in_b, in_op operand set
//   alu_a/alu_b/alu_op         FIFO head to the ALU (zeros when empty)
//   alu_c                      combinational ALU result for the head
//   out_valid/out_ready        writeback handshake; out_c result, out_op tag
//   op_count                   results accepted downstream (wraps)
module alu_issue_buf
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int OPW   = alu_pkg::OPW,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [OPW-1:0]   out_op,
    output logic [31:0]      op_count
);

    localparam int EW = 2*WIDTH + OPW;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [EW-1:0]    w_push_data;
    logic [EW-1:0]    w_head;
    logic [CW-1:0]    w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_load;
    logic             w_out_fire;
    logic [WIDTH-1:0] w_head_a;
    logic [WIDTH-1:0] w_head_b;
    logic [OPW-1:0]   w_head_op;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_c;
    logic [OPW-1:0]   r_out_op;
    logic [31:0]      r_op_count;

    assign w_push_data = {in_a, in_b, in_op};
    assign {w_head_a, w_head_b, w_head_op} = w_head;

    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == CW'(DEPTH));

    // in_ready depends only on FIFO occupancy, never on out_ready, so no
    // combinational path runs from writeback back to decode.
    assign in_ready   = !w_full;
    assign w_push     = in_valid && !w_full;
    assign w_out_fire = r_out_valid && out_ready;
    // The result register refills whenever it is empty or being drained this cycle.
    assign w_load     = !w_empty && (!r_out_valid || out_ready);

    sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_load),
        .i_data  (w_push_data),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Hold the ALU inputs at zero while the FIFO is empty so it does not
    // toggle on stale storage.
    // NOTE: every output gets a default first so the block can never infer a latch.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (!w_empty) begin
            alu_a  = w_head_a;
            alu_b  = w_head_b;
            alu_op = w_head_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_c     <= '0;
            r_out_op    <= '0;
            r_op_count  <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_c     <= alu_c;
                r_out_op    <= w_head_op;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_fire) r_op_count <= r_op_count + 32'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_c     = r_out_c;
    assign out_op    = r_out_op;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_issue_buf.sv
// Self-checking bench for alu_issue_buf with a behavioural ALU on alu_c.
// A queue-based model of the issue stage is compared with the DUT on every
// falling edge; directed phases pin the model with literal expectations and
// a randomized phase exercises stalls and pointer wrap.
module tb_alu_issue_buf;
    import alu_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_op = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_c;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_c;
    logic [2:0]  out_op;
    logic [31:0] op_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_buf #(.WIDTH(32), .OPW(3), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_op    (out_op),
        .op_count  (op_count)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SRL: return a >> b[4:0];
            ALU_SRA: return 32'($signed(a) >>> b[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    // The ALU the issue stage feeds.
    assign alu_c = alu_ref(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    operand_t    m_fifo[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_c = '0;
    logic [2:0]  m_op = '0;
    logic [31:0] m_count = '0;
    bit          model_live = 1'b0;

    initial forever begin
        @(posedge clk);
        if (!reset) begin
            m_fifo.delete();
            m_valid    = 1'b0;
            m_c        = '0;
            m_op       = '0;
            m_count    = '0;
            model_live = 1'b1;
        end else if (model_live) begin
            bit       hs, ld, pu;
            operand_t h;
            hs = m_valid && out_ready;
            ld = (m_fifo.size() != 0) && (!m_valid || out_ready);
            pu = in_valid && (m_fifo.size() < DEPTH);
            if (hs) m_count = m_count + 1;
            if (ld) begin
                h       = m_fifo.pop_front();
                m_c     = alu_ref(h.a, h.b, h.op);
                m_op    = h.op;
                m_valid = 1'b1;
            end else if (hs) begin
                m_valid = 1'b0;
            end
            if (pu) m_fifo.push_back('{a: in_a, b: in_b, op: in_op});
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_live) begin
            check("in_ready",  in_ready,  m_fifo.size() != DEPTH);
            check("out_valid", out_valid, m_valid);
            check("out_c",     out_c,     m_c);
            check("out_op",    out_op,    m_op);
            check("op_count",  op_count,  m_count);
            check("alu_a", alu_a, (m_fifo.size() != 0) ? m_fifo[0].a : 32'd0);
            check("alu_b", alu_b, (m_fifo.size() != 0) ? m_fifo[0].b : 32'd0);
            check("alu_op", alu_op, (m_fifo.size() != 0) ? m_fifo[0].op : 3'd0);
        end
    end

    // ---------------- downstream monitor ----------------
    typedef struct {
        logic [31:0] c;
        logic [2:0]  op;
        int          cyc;
    } res_t;
    res_t got[$];

    initial forever begin
        @(posedge clk);
        if (reset && out_valid === 1'b1 && out_ready)
            got.push_back('{c: out_c, op: out_op, cyc: cyc});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bit acc = 1'b0;
        int n   = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        while (!acc && n < 100) begin
            @(posedge clk);
            acc = in_ready;
            #2;
            n++;
        end
        in_valid = 1'b0;
        check("send_accept", acc, 1'b1);
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (got.size() < n && k < 300) begin
            step();
            k++;
        end
        check("result_count", got.size(), n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] s_a [4] = '{32'd5, 32'h0000_00F0, 32'h0000_00F0, 32'h8000_0000};
    logic [31:0] s_b [4] = '{32'd3, 32'h0000_003C, 32'h0000_000F, 32'd4};
    logic [2:0]  s_op[4] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_SRA};
    logic [31:0] s_c [4] = '{32'd2, 32'h0000_0030, 32'h0000_00FF, 32'hF800_0000};
    logic [31:0] bp_c[3] = '{32'd30, 32'd99, 32'h0000_000F};
    res_t        sent[$];

    initial begin
        // Reset held 2 cycles with in_valid asserted: nothing may be captured.
        reset = 1'b0;
        in_valid = 1'b1;
        in_a = 32'h1234;
        in_b = 32'h1;
        step();
        step();
        reset = 1'b1;
        in_valid = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_c", out_c, 32'd0);
        check("rst_op_count", op_count, 32'd0);
        check("rst_in_ready", in_ready, 1'b1);
        step();
        check("rst_idle_valid", out_valid, 1'b0);

        // Single op: result one edge after acceptance.
        out_ready = 1'b1;
        got.delete();
        send(32'd1, 32'd2, ALU_ADD);
        check("single_not_yet", out_valid, 1'b0);
        step();
        check("single_valid", out_valid, 1'b1);
        check("single_c", out_c, 32'd3);
        check("single_op", out_op, ALU_ADD);
        check("single_cnt_before", op_count, 32'd0);
        step();
        check("single_cnt_after", op_count, 32'd1);
        check("single_drained", out_valid, 1'b0);

        // Back-to-back stream: four results on consecutive cycles.
        got.delete();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_a = s_a[i];
            in_b = s_b[i];
            in_op = s_op[i];
            @(posedge clk);
            check("stream_in_ready", in_ready, 1'b1);
            #2;
        end
        in_valid = 1'b0;
        wait_results(4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            check("stream_c", got[i].c, s_c[i]);
            check("stream_cyc", got[i].cyc - got[0].cyc, i);
        end

        // Backpressure: first result held, FIFO fills, then drains in order.
        out_ready = 1'b0;
        got.delete();
        send(32'd10, 32'd20, ALU_ADD);
        send(32'd100, 32'd1, ALU_SUB);
        send(32'hFF, 32'h0F, ALU_AND);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_valid", out_valid, 1'b1);
        check("bp_first_c", out_c, 32'd30);
        step();
        step();
        check("bp_hold_c", out_c, 32'd30);
        check("bp_hold_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        wait_results(3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            check("bp_order_c", got[i].c, bp_c[i]);
        check("bp_op_count", op_count, 32'd8);

        // Reset mid-stream with FIFO full and a result held.
        out_ready = 1'b0;
        send(32'd1, 32'd1, ALU_ADD);
        send(32'd2, 32'd2, ALU_ADD);
        send(32'd3, 32'd3, ALU_ADD);
        check("mid_full", in_ready, 1'b0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("mid_valid", out_valid, 1'b0);
        check("mid_c", out_c, 32'd0);
        check("mid_cnt", op_count, 32'd0);
        check("mid_ready", in_ready, 1'b1);
        check("mid_alu_a", alu_a, 32'd0);
        out_ready = 1'b1;
        got.delete();
        send(32'd7, 32'd8, ALU_ADD);
        wait_results(1);
        if (got.size() > 0) check("mid_next_c", got[0].c, 32'd15);

        // Randomized traffic with stalls on both sides; wraps pointers many times.
        got.delete();
        sent.delete();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = $urandom;
            in_b      = $urandom;
            in_op     = 3'($urandom_range(0, 5));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            if (in_valid && in_ready)
                sent.push_back('{c: alu_ref(in_a, in_b, in_op), op: in_op, cyc: 0});
            #2;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_results(sent.size());
        for (int i = 0; i < sent.size() && i < got.size(); i++) begin
            check("rand_c", got[i].c, sent[i].c);
            check("rand_op", got[i].op, sent[i].op);
        end
        check("rand_enough", sent.size() > 2*DEPTH+1, 1'b1);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
